scan_timing_generator: RTL and testbench

SCAN_TIMING_GENERATOR -- requirements
Module: scan_timing_generator

---
 rtl/scan_timing_generator.sv | 140 ++++++++++++++
 tb/tb_scan_timing_generator.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_timing_generator.sv
// ---------------------------------------------------------------------------
// scan_timing_generator
//
// Raster scan timing for a VGA-style display. A clock divider produces a
// pixel-tick strobe. A horizontal/vertical position counter pair advances on
// each tick. The sync and video outputs are registered one pixel tick behind
// the position, so sprite logic can look up "graphics" for the current
// scan_x/scan_y and have it line up with the sync pulses.
//
// Ports
//   clk          sole clock
//   rst          synchronous active-high reset
//   graphics     pixel value from sprite blocks for the current scan_x/scan_y
//   pix_en       pixel-tick strobe (combinational, from the divider)
//   scan_x       current horizontal position, 0..H_TOTAL-1
//   scan_y       current vertical position, 0..V_TOTAL-1
//   active       scan_x/scan_y lies inside the visible area (combinational)
//   line_start   one-clk pulse on the cycle after scan_x wrapped to 0
//   frame_start  one-clk pulse on the cycle after both counters wrapped to 0
//   frame_count  completed-frame counter, wraps modulo 2^16
//   hsync        registered horizontal sync, polarity set by SYNC_ACTIVE_LOW
//   vsync        registered vertical sync, polarity set by SYNC_ACTIVE_LOW
//   video        registered pixel output, forced to 0 during blanking
// ---------------------------------------------------------------------------
module scan_timing_generator #(
   parameter int H_ACTIVE        = 640,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int V_ACTIVE        = 480,
   parameter int V_FP            = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter int CLK_DIV         = 2,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        graphics,
   output logic        pix_en,
   output logic [15:0] scan_x,
   output logic [15:0] scan_y,
   output logic        active,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count,
   output logic        hsync,
   output logic        vsync,
   output logic        video
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // A divide-by-one still needs a one-bit counter that simply stays at zero.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [15:0] X_LAST       = 16'(H_TOTAL - 1);
   localparam logic [15:0] Y_LAST       = 16'(V_TOTAL - 1);
   localparam logic [15:0] X_VISIBLE    = 16'(H_ACTIVE);
   localparam logic [15:0] Y_VISIBLE    = 16'(V_ACTIVE);
   localparam logic [15:0] HSYNC_FIRST  = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HSYNC_END    = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] VSYNC_FIRST  = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VSYNC_END    = 16'(V_ACTIVE + V_FP + V_SYNC);

   // Idle level of the sync outputs: high for active-low sync, low otherwise.
   localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

   logic [DIV_W-1:0] div_cnt;
   logic             x_wrap;
   logic             y_wrap;
   logic             hsync_raw;
   logic             vsync_raw;

   assign pix_en    = (div_cnt == DIV_LAST);
   assign active    = (scan_x < X_VISIBLE) && (scan_y < Y_VISIBLE);
   assign x_wrap    = (scan_x == X_LAST);
   assign y_wrap    = (scan_y == Y_LAST);
   assign hsync_raw = (scan_x >= HSYNC_FIRST) && (scan_x < HSYNC_END);
   assign vsync_raw = (scan_y >= VSYNC_FIRST) && (scan_y < VSYNC_END);

   // Clock divider: counts 0..CLK_DIV-1; the terminal count is the pixel tick,
   // so after reset the first tick lands CLK_DIV cycles later.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (pix_en) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Position counters and the start-of-line/frame markers. The markers are
   // registered from the wrap condition so they appear on the first cycle the
   // counters read zero, and the frame counter bumps on that same edge.
   // Reset wins over any wrap that would otherwise happen on this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_x      <= '0;
         scan_y      <= '0;
         frame_count <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_en && x_wrap;
         frame_start <= pix_en && x_wrap && y_wrap;
         if (pix_en) begin
            if (x_wrap) begin
               scan_x <= '0;
               if (y_wrap) begin
                  scan_y      <= '0;
                  frame_count <= frame_count + 16'd1;
               end else begin
                  scan_y <= scan_y + 16'd1;
               end
            end else begin
               scan_x <= scan_x + 16'd1;
            end
         end
      end
   end

   // Output pipeline: captures sync and the blanked pixel once per tick, so
   // graphics is only looked at on tick edges and the outputs hold in between.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync <= SYNC_IDLE;
         vsync <= SYNC_IDLE;
         video <= 1'b0;
      end else if (pix_en) begin
         hsync <= SYNC_ACTIVE_LOW ? ~hsync_raw : hsync_raw;
         vsync <= SYNC_ACTIVE_LOW ? ~vsync_raw : vsync_raw;
         video <= graphics & active;
      end
   end

endmodule

// File: tb/tb_scan_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_scan_timing_generator
//
// Four instances share one clock:
//   0: default VGA timing, CLK_DIV=2 (reset release table, one full line)
//   1: tiny raster, CLK_DIV=2 (full frames, mid-frame reset)
//   2: 1x1 raster, CLK_DIV=1 (a frame per clock, frame_count wrap)
//   3: tiny raster, CLK_DIV=1, active-high sync
// Each instance is also compared every cycle against a reference that derives
// position, markers and pipelined outputs from the elapsed clock count.
// ---------------------------------------------------------------------------
module tb_scan_timing_generator;

   typedef struct packed {
      int cd;
      int ha;
      int hf;
      int hs;
      int hb;
      int va;
      int vf;
      int vs;
      int vb;
      int low;
   } geom_t;

   typedef struct packed {
      logic        pix_en;
      logic [15:0] scan_x;
      logic [15:0] scan_y;
      logic        active;
      logic        line_start;
      logic        frame_start;
      logic [15:0] frame_count;
      logic        hsync;
      logic        vsync;
      logic        video;
   } obs_t;

   typedef struct {
      bit          rst;
      bit          gfx;
      bit          pix;
      logic [15:0] x;
      bit          hs;
      bit          vs;
      bit          vid;
   } vec_t;

   localparam geom_t G [4] = '{
      '{cd: 2, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, low: 1},
      '{cd: 2, ha: 8,   hf: 2,  hs: 3,  hb: 2,  va: 6,   vf: 1,  vs: 2, vb: 1,  low: 1},
      '{cd: 1, ha: 1,   hf: 0,  hs: 0,  hb: 0,  va: 1,   vf: 0,  vs: 0, vb: 0,  low: 1},
      '{cd: 1, ha: 8,   hf: 2,  hs: 3,  hb: 2,  va: 6,   vf: 1,  vs: 2, vb: 1,  low: 0}
   };

   logic        clk;
   logic        rst_r  [4];
   logic        gfx_w  [4];
   bit          g_fix  [4];
   bit          g_rand [4];
   logic        pix_w  [4];
   logic [15:0] x_w    [4];
   logic [15:0] y_w    [4];
   logic        act_w  [4];
   logic        ls_w   [4];
   logic        fs_w   [4];
   logic [15:0] fc_w   [4];
   logic        hs_w   [4];
   logic        vs_w   [4];
   logic        vid_w  [4];
   bit          mon_en;
   int          checks;
   int          errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: everything follows from the count of clocks since reset.
   function automatic obs_t model(input geom_t g, input int c, input logic last_g);
      obs_t o;
      int   ht, vt, fr, n, p, px, py;
      logic hr, vr;
      ht = g.ha + g.hf + g.hs + g.hb;
      vt = g.va + g.vf + g.vs + g.vb;
      fr = ht * vt;
      n  = c / g.cd;
      p  = n % fr;
      o.pix_en      = ((c % g.cd) == (g.cd - 1));
      o.scan_x      = 16'(p % ht);
      o.scan_y      = 16'(p / ht);
      o.active      = ((p % ht) < g.ha) && ((p / ht) < g.va);
      o.line_start  = (c > 0) && ((c % g.cd) == 0) && ((n % ht) == 0);
      o.frame_start = (c > 0) && ((c % g.cd) == 0) && (p == 0);
      o.frame_count = 16'(n / fr);
      if (n == 0) begin
         hr      = 1'b0;
         vr      = 1'b0;
         o.video = 1'b0;
      end else begin
         px      = ((n - 1) % fr) % ht;
         py      = ((n - 1) % fr) / ht;
         hr      = (px >= g.ha + g.hf) && (px < g.ha + g.hf + g.hs);
         vr      = (py >= g.va + g.vf) && (py < g.va + g.vf + g.vs);
         o.video = last_g && (px < g.ha) && (py < g.va);
      end
      o.hsync = (g.low != 0) ? !hr : hr;
      o.vsync = (g.low != 0) ? !vr : vr;
      return o;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Instance 0 table driver: inputs for one cycle, then sample at negedge.
   task automatic applyStimulus(input bit r, input bit g);
      @(posedge clk);
      #1;
      rst_r[0] = r;
      g_fix[0] = g;
      @(negedge clk);
   endtask

   // Graphics driver: changes every cycle after the edge, so random mode also
   // toggles graphics between pixel ticks.
   initial begin
      for (int k = 0; k < 4; k++) gfx_w[k] = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         for (int k = 0; k < 4; k++) gfx_w[k] = g_rand[k] ? 1'($urandom) : g_fix[k];
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_dut
      obs_t o;

      scan_timing_generator #(
         .H_ACTIVE(G[k].ha), .H_FP(G[k].hf), .H_SYNC(G[k].hs), .H_BP(G[k].hb),
         .V_ACTIVE(G[k].va), .V_FP(G[k].vf), .V_SYNC(G[k].vs), .V_BP(G[k].vb),
         .CLK_DIV(G[k].cd), .SYNC_ACTIVE_LOW(G[k].low != 0)
      ) u_dut (
         .clk(clk),
         .rst(rst_r[k]),
         .graphics(gfx_w[k]),
         .pix_en(pix_w[k]),
         .scan_x(x_w[k]),
         .scan_y(y_w[k]),
         .active(act_w[k]),
         .line_start(ls_w[k]),
         .frame_start(fs_w[k]),
         .frame_count(fc_w[k]),
         .hsync(hs_w[k]),
         .vsync(vs_w[k]),
         .video(vid_w[k])
      );

      assign o = '{pix_en: pix_w[k], scan_x: x_w[k], scan_y: y_w[k], active: act_w[k],
                   line_start: ls_w[k], frame_start: fs_w[k], frame_count: fc_w[k],
                   hsync: hs_w[k], vsync: vs_w[k], video: vid_w[k]};

      // Per-cycle comparison against the reference; the cycle count restarts
      // whenever reset is applied on the coming edge.
      initial begin : monitor
         int   cyc;
         int   mon_err;
         logic last_g;
         obs_t e;
         cyc     = 0;
         mon_err = 0;
         last_g  = 1'b0;
         forever begin
            @(negedge clk);
            if (mon_en) begin
               e = model(G[k], cyc, last_g);
               if (mon_err < 10) begin
                  checks++;
                  if (o !== e) begin
                     errors++;
                     mon_err++;
                     $display("[TB] FAIL model%0d cyc %0d got %h expected %h", k, cyc, o, e);
                  end
               end
               if (rst_r[k]) begin
                  cyc = 0;
               end else begin
                  if (e.pix_en) last_g = gfx_w[k];
                  cyc++;
               end
            end
         end
      end
   end

   initial begin
      vec_t tbl [7];
      checks = 0;
      errors = 0;
      mon_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rst_r[k]  = 1'b1;
         g_fix[k]  = 1'b0;
         g_rand[k] = 1'b0;
      end

      // Reset hold then release at CLK_DIV=2; graphics high inside reset
      // must not reach video.
      tbl[0] = '{rst: 1, gfx: 0, pix: 0, x: 16'd0, hs: 1, vs: 1, vid: 0};
      tbl[1] = '{rst: 1, gfx: 1, pix: 0, x: 16'd0, hs: 1, vs: 1, vid: 0};
      tbl[2] = '{rst: 0, gfx: 0, pix: 0, x: 16'd0, hs: 1, vs: 1, vid: 0};
      tbl[3] = '{rst: 0, gfx: 0, pix: 1, x: 16'd0, hs: 1, vs: 1, vid: 0};
      tbl[4] = '{rst: 0, gfx: 0, pix: 0, x: 16'd1, hs: 1, vs: 1, vid: 0};
      tbl[5] = '{rst: 0, gfx: 0, pix: 1, x: 16'd1, hs: 1, vs: 1, vid: 0};
      tbl[6] = '{rst: 0, gfx: 0, pix: 0, x: 16'd2, hs: 1, vs: 1, vid: 0};

      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;

      fork
         // Instance 0: reset release table, then one full line with graphics=1.
         begin
            int  ls_count, hs_ticks, first_low_x, max_x, ls_x, ls_y;
            bit  done;
            for (int i = 0; i < 7; i++) begin
               applyStimulus(tbl[i].rst, tbl[i].gfx);
               checkOutput($sformatf("tbl%0d_pix", i), 64'(pix_w[0]), 64'(tbl[i].pix));
               checkOutput($sformatf("tbl%0d_x", i),   64'(x_w[0]),   64'(tbl[i].x));
               checkOutput($sformatf("tbl%0d_hs", i),  64'(hs_w[0]),  64'(tbl[i].hs));
               checkOutput($sformatf("tbl%0d_vs", i),  64'(vs_w[0]),  64'(tbl[i].vs));
               checkOutput($sformatf("tbl%0d_vid", i), 64'(vid_w[0]), 64'(tbl[i].vid));
            end
            g_fix[0]    = 1'b1;
            ls_count    = 0;
            hs_ticks    = 0;
            first_low_x = -1;
            max_x       = 0;
            ls_x        = -1;
            ls_y        = -1;
            done        = 1'b0;
            for (int i = 0; i < 3400 && !done; i++) begin
               @(negedge clk);
               if (y_w[0] == 16'd0) begin
                  if (int'(x_w[0]) > max_x) max_x = int'(x_w[0]);
                  if (!hs_w[0]) begin
                     if (first_low_x < 0) first_low_x = int'(x_w[0]);
                     if (pix_w[0]) hs_ticks++;
                  end
               end
               if (ls_w[0]) begin
                  ls_count++;
                  ls_x = int'(x_w[0]);
                  ls_y = int'(y_w[0]);
               end
               if (y_w[0] == 16'd1 && x_w[0] == 16'd3) done = 1'b1;
            end
            checkOutput("line_done",       64'(done),        64'd1);
            checkOutput("line_max_x",      64'(max_x),       64'd799);
            checkOutput("hsync_first_x",   64'(first_low_x), 64'd657);
            checkOutput("hsync_ticks",     64'(hs_ticks),    64'd96);
            checkOutput("line_start_cnt",  64'(ls_count),    64'd1);
            checkOutput("line_start_x",    64'(ls_x),        64'd0);
            checkOutput("line_start_y",    64'(ls_y),        64'd1);
         end

         // Instance 1: one full frame, then reset inside the sync corner.
         begin
            int  fs_count, vs_ticks, first_vx, first_vy, ls_at_fs;
            bit  found;
            @(posedge clk);
            #1;
            rst_r[1]  = 1'b0;
            g_rand[1] = 1'b1;
            fs_count  = 0;
            vs_ticks  = 0;
            first_vx  = -1;
            first_vy  = -1;
            ls_at_fs  = 0;
            found     = 1'b0;
            for (int i = 0; i < 400 && !found; i++) begin
               @(negedge clk);
               if (!vs_w[1]) begin
                  if (first_vx < 0) begin
                     first_vx = int'(x_w[1]);
                     first_vy = int'(y_w[1]);
                  end
                  if (pix_w[1]) vs_ticks++;
               end
               if (fs_w[1]) begin
                  fs_count++;
                  if (ls_w[1]) ls_at_fs++;
               end
               if (fc_w[1] == 16'd1) found = 1'b1;
            end
            checkOutput("frame_done",     64'(found),    64'd1);
            checkOutput("frame_start_n",  64'(fs_count), 64'd1);
            checkOutput("fs_with_ls",     64'(ls_at_fs), 64'd1);
            checkOutput("vsync_ticks",    64'(vs_ticks), 64'd30);
            checkOutput("vsync_first_x",  64'(first_vx), 64'd1);
            checkOutput("vsync_first_y",  64'(first_vy), 64'd7);

            found = 1'b0;
            for (int i = 0; i < 400 && !found; i++) begin
               @(negedge clk);
               if (!hs_w[1] && !vs_w[1]) found = 1'b1;
            end
            checkOutput("sync_corner_seen", 64'(found), 64'd1);
            @(posedge clk);
            #1;
            rst_r[1] = 1'b1;
            @(posedge clk);
            #1;
            rst_r[1] = 1'b0;
            @(negedge clk);
            checkOutput("mid_rst_x",  64'(x_w[1]),   64'd0);
            checkOutput("mid_rst_y",  64'(y_w[1]),   64'd0);
            checkOutput("mid_rst_hs", 64'(hs_w[1]),  64'd1);
            checkOutput("mid_rst_vs", 64'(vs_w[1]),  64'd1);
            checkOutput("mid_rst_vid", 64'(vid_w[1]), 64'd0);
            checkOutput("mid_rst_fs", 64'(fs_w[1]),  64'd0);
            checkOutput("mid_rst_ls", 64'(ls_w[1]),  64'd0);
            checkOutput("mid_rst_fc", 64'(fc_w[1]),  64'd0);
            @(negedge clk);
            checkOutput("resume_pix", 64'(pix_w[1]), 64'd1);
            checkOutput("resume_x0",  64'(x_w[1]),   64'd0);
            @(negedge clk);
            checkOutput("resume_x1",  64'(x_w[1]),   64'd1);
            repeat (700) @(negedge clk);
         end

         // Instance 2: a frame per clock, run frame_count through its wrap.
         begin
            bit found;
            @(posedge clk);
            #1;
            rst_r[2]  = 1'b0;
            g_rand[2] = 1'b1;
            found     = 1'b0;
            for (int i = 0; i < 70000 && !found; i++) begin
               @(negedge clk);
               if (fc_w[2] == 16'hFFFF) found = 1'b1;
            end
            checkOutput("fc_reach_ffff", 64'(found), 64'd1);
            @(negedge clk);
            checkOutput("fc_wrap_zero", 64'(fc_w[2]),  64'd0);
            checkOutput("fc_wrap_fs",   64'(fs_w[2]),  64'd1);
            checkOutput("fc_wrap_pix",  64'(pix_w[2]), 64'd1);
         end

         // Instance 3: CLK_DIV=1, position must move on every clock.
         begin
            logic [15:0] prev_x;
            @(posedge clk);
            #1;
            rst_r[3]  = 1'b0;
            g_rand[3] = 1'b1;
            repeat (20) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
               prev_x = x_w[3];
               @(negedge clk);
               checkOutput($sformatf("div1_adv%0d", i), 64'(x_w[3]), 64'((int'(prev_x) + 1) % 15));
            end
            repeat (400) @(negedge clk);
         end
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
